// File: rtl/commit_pkg.sv
// commit_pkg: shared types and constants for the in-order commit stage.
// Optional feature macro used by commit_unit: COMMIT_PERF_EN (retire/stall counters).
package commit_pkg;

    // Width of the optional performance counters.
    localparam int PERF_CNT_W = 32;

    // Architectural register file write widths carried by arf_wr_t.
    // The commit_unit DATA_WIDTH / REG_ADDR_WIDTH defaults are tied to these.
    localparam int ARF_DATA_W = 32;
    localparam int ARF_ADDR_W = 5;

    // Retirement controller states.
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } commit_state_t;

    // One architectural register write, as presented to the register file.
    typedef struct packed {
        logic                  we;
        logic [ARF_ADDR_W-1:0] waddr;
        logic [ARF_DATA_W-1:0] wdata;
    } arf_wr_t;

    // Increment a performance counter by one when en is set; wraps naturally.
    function automatic logic [PERF_CNT_W-1:0] perf_inc(
        input logic [PERF_CNT_W-1:0] cnt,
        input logic                  en
    );
        return cnt + {{(PERF_CNT_W-1){1'b0}}, en};
    endfunction

endpackage

// File: rtl/commit_unit_completion_table.sv
// completion_table: tag-indexed done/exc/value storage.
// A set (result broadcast) on a tag wins over a clear (commit) on the same tag.
// clr_all holds every done/exc bit cleared and blocks sets while it is high.
module completion_table
    import commit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_tag,
    input  logic                  set_exc,
    input  logic [DATA_WIDTH-1:0] set_value,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_tag,
    input  logic                  clr_all,
    input  logic [ADDR_WIDTH-1:0] rd_tag,
    output logic                  rd_done,
    output logic                  rd_exc,
    output logic [DATA_WIDTH-1:0] rd_value
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DEPTH-1:0]                 done_r;
    logic [DEPTH-1:0]                 exc_r;
    logic [DEPTH-1:0]                 done_s;
    logic [DEPTH-1:0]                 exc_s;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] value_r;
    logic                             wr_value_s;

    // Next-state of the done/exc bit vectors: flush-clear, then commit-clear, then set.
    always_comb begin
        done_s = done_r;
        exc_s  = exc_r;
        if (clr_all) begin
            done_s = '0;
            exc_s  = '0;
        end else begin
            if (clr_en) begin
                done_s[clr_tag] = 1'b0;
            end else begin
                done_s = done_s;
            end
            if (set_en) begin
                done_s[set_tag] = 1'b1;
                exc_s[set_tag]  = set_exc;
            end else begin
                exc_s = exc_s;
            end
        end
    end

    assign wr_value_s = set_en && !clr_all;

    // Done/exc bit storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_r <= '0;
            exc_r  <= '0;
        end else begin
            done_r <= done_s;
            exc_r  <= exc_s;
        end
    end

    // Result value storage, written by accepted broadcasts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_r <= '0;
        end else if (wr_value_s) begin
            value_r[set_tag] <= set_value;
        end else begin
            value_r <= value_r;
        end
    end

    assign rd_done  = done_r[rd_tag];
    assign rd_exc   = exc_r[rd_tag];
    assign rd_value = value_r[rd_tag];

endmodule

// File: rtl/commit_unit.sv
// commit_unit: in-order retirement stage behind the reorder buffer.
// Pops the ROB head once its result is complete, writes the architectural
// register file, and on an excepting head raises a one-cycle flush and then
// drains the ROB without writing registers.
// Optional feature: define COMMIT_PERF_EN to add instret / stall_cycles counters.
module commit_unit
    import commit_pkg::*;
#(
    parameter int DATA_WIDTH     = ARF_DATA_W,
    parameter int ADDR_WIDTH     = 4,
    parameter int REG_ADDR_WIDTH = ARF_ADDR_W,
    parameter int PC_WIDTH       = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rob_empty,
    input  logic [ADDR_WIDTH-1:0]     rob_head_tag,
    input  logic [REG_ADDR_WIDTH-1:0] rob_head_rd,
    input  logic                      rob_head_we,
    input  logic [PC_WIDTH-1:0]       rob_head_pc,
    output logic                      rob_rd,
    input  logic                      cdb_valid,
    input  logic [ADDR_WIDTH-1:0]     cdb_tag,
    input  logic [DATA_WIDTH-1:0]     cdb_data,
    input  logic                      cdb_exc,
    output logic                      arf_we,
    output logic [REG_ADDR_WIDTH-1:0] arf_waddr,
    output logic [DATA_WIDTH-1:0]     arf_wdata,
    output logic                      flush,
    output logic [PC_WIDTH-1:0]       flush_pc
`ifdef COMMIT_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0]     instret,
    output logic [PERF_CNT_W-1:0]     stall_cycles
`endif
);

    commit_state_t             state_r;
    commit_state_t             state_s;
    logic                      rob_rd_s;
    logic                      commit_s;
    logic                      retire_s;
    logic                      except_s;
    logic                      drain_s;
    logic                      head_done_s;
    logic                      head_exc_s;
    logic [DATA_WIDTH-1:0]     head_value_s;
    arf_wr_t                   arf_r;
    logic                      flush_r;
    logic [PC_WIDTH-1:0]       flush_pc_r;

    // The table is held clear (and deaf to broadcasts) for the whole drain.
    assign drain_s = (state_r == DRAIN);

    completion_table #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_table (
        .clk       (clk),
        .reset     (reset),
        .set_en    (cdb_valid),
        .set_tag   (cdb_tag),
        .set_exc   (cdb_exc),
        .set_value (cdb_data),
        .clr_en    (commit_s),
        .clr_tag   (rob_head_tag),
        .clr_all   (drain_s),
        .rd_tag    (rob_head_tag),
        .rd_done   (head_done_s),
        .rd_exc    (head_exc_s),
        .rd_value  (head_value_s)
    );

    // Retirement state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= RUN;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and pop decision; at most one pop per cycle, never when empty.
    always_comb begin
        state_s  = state_r;
        rob_rd_s = 1'b0;
        commit_s = 1'b0;
        case (state_r)
            RUN: begin
                if (!rob_empty && head_done_s) begin
                    rob_rd_s = 1'b1;
                    commit_s = 1'b1;
                    if (head_exc_s) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                rob_rd_s = !rob_empty;
                if (rob_empty) begin
                    state_s = RUN;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = RUN;
            end
        endcase
    end

    assign retire_s = commit_s && !head_exc_s;
    assign except_s = commit_s && head_exc_s;
    assign rob_rd   = rob_rd_s;

    // Registered register-file write for each non-excepting retirement.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arf_r <= '0;
        end else if (retire_s) begin
            arf_r.we    <= rob_head_we;
            arf_r.waddr <= rob_head_rd;
            arf_r.wdata <= head_value_s;
        end else begin
            arf_r.we <= 1'b0;
        end
    end

    // Registered one-cycle flush pulse with the faulting PC held afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_r    <= 1'b0;
            flush_pc_r <= '0;
        end else begin
            flush_r <= except_s;
            if (except_s) begin
                flush_pc_r <= rob_head_pc;
            end else begin
                flush_pc_r <= flush_pc_r;
            end
        end
    end

    assign arf_we    = arf_r.we;
    assign arf_waddr = arf_r.waddr;
    assign arf_wdata = arf_r.wdata;
    assign flush     = flush_r;
    assign flush_pc  = flush_pc_r;

`ifdef COMMIT_PERF_EN
    logic [PERF_CNT_W-1:0] instret_r;
    logic [PERF_CNT_W-1:0] stall_r;
    logic                  stall_s;

    // A stall is a RUN cycle whose head exists but has not completed.
    assign stall_s = (state_r == RUN) && !rob_empty && !head_done_s;

    // Retirement and stall counters, wrapping at 2**PERF_CNT_W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret_r <= '0;
            stall_r   <= '0;
        end else begin
            instret_r <= perf_inc(instret_r, retire_s);
            stall_r   <= perf_inc(stall_r, stall_s);
        end
    end

    assign instret      = instret_r;
    assign stall_cycles = stall_r;
`endif

endmodule
